// File: rtl/ifu_axil_fetch.sv
// ifu_axil_fetch: single-outstanding AXI4-Lite instruction fetch feeding decode
// Optional feature macro: IFU_TIMEOUT_EN (per-phase AR/R watchdog that aborts with ebreak)
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   pc, s_valid      fetch request (address sampled when s_valid && s_ready)
//   s_ready          high only while idle
//   inst, pc_out     fetched word and its address, held while m_valid
//   m_valid, m_ready decode handshake
//   fetch_err        marks the current m_valid beat as a failed fetch
//   araddr, arvalid, arready            AXI read address channel
//   rdata, rresp, rvalid, rready        AXI read data channel
module ifu_axil_fetch #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] pc_out,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              fetch_err,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready
);
    typedef enum logic [1:0] {IDLE, AR, R, HOLD} state_t;
    localparam logic [DATA_W-1:0] EBREAK = DATA_W'(32'h0010_0073);

    if (DATA_W != 32) begin : g_bad_data_w
        $error("ifu_axil_fetch supports DATA_W == 32 only");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("ifu_axil_fetch requires TIMEOUT >= 1");
    end

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic              err_q, err_d;
    logic              s_ready_q, arvalid_q, rready_q, m_valid_q;

`ifdef IFU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy, entering;
    assign busy     = (state_q == AR) || (state_q == R);
    assign entering = (state_d != state_q) && ((state_d == AR) || (state_d == R));
    assign cnt_d    = entering ? '0 : busy ? cnt_q + CW'(1) : cnt_q;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        inst_d  = inst_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (s_valid) begin
                addr_d  = pc;
                state_d = AR;
            end
            AR:   if (arready) state_d = R;
            R:    if (rvalid) begin
                inst_d  = (rresp == 2'b00) ? rdata : EBREAK;
                err_d   = (rresp != 2'b00);
                state_d = HOLD;
            end
            HOLD: if (m_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef IFU_TIMEOUT_EN
        // a completing handshake in the same cycle wins over the watchdog
        if (busy && cnt_q == CW'(TIMEOUT) && state_d == state_q) begin
            inst_d  = EBREAK;
            err_d   = 1'b1;
            state_d = HOLD;
        end
`endif
    end

    // handshake outputs are registered copies of the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            inst_q    <= '0;
            err_q     <= 1'b0;
            s_ready_q <= 1'b1;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            m_valid_q <= 1'b0;
`ifdef IFU_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            inst_q    <= inst_d;
            err_q     <= err_d;
            s_ready_q <= (state_d == IDLE);
            arvalid_q <= (state_d == AR);
            rready_q  <= (state_d == R);
            m_valid_q <= (state_d == HOLD);
`ifdef IFU_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign s_ready   = s_ready_q;
    assign arvalid   = arvalid_q;
    assign rready    = rready_q;
    assign m_valid   = m_valid_q;
    assign araddr    = addr_q;
    assign pc_out    = addr_q;
    assign inst      = inst_q;
    assign fetch_err = err_q;
endmodule

// File: tb/tb_ifu_axil_fetch.sv
// tb_ifu_axil_fetch: directed self-checking bench for ifu_axil_fetch
module tb_ifu_axil_fetch;
`ifdef IFU_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] inst;
    logic [31:0] pc_out;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        fetch_err;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = 2'b00;
    logic        rvalid = 1'b0;
    logic        rready;

    int n_chk = 0;
    int n_fail = 0;

    ifu_axil_fetch #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .pc(pc), .s_valid(s_valid), .s_ready(s_ready),
        .inst(inst), .pc_out(pc_out), .m_valid(m_valid), .m_ready(m_ready),
        .fetch_err(fetch_err), .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tick();
        tick();
        check("rst_s_ready", s_ready, 1);
        check("rst_arvalid", arvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_fetch_err", fetch_err, 0);
        check("rst_inst", inst, 0);
        check("rst_pc_out", pc_out, 0);
        check("rst_araddr", araddr, 0);
        rst = 1'b0;
        tick();

        // zero-wait fetch
        pc = 32'h8000_0000; s_valid = 1'b1; arready = 1'b1; rvalid = 1'b1;
        rdata = 32'h0000_0413; rresp = 2'b00; m_ready = 1'b1;
        tick();
        s_valid = 1'b0;
        check("c1_arvalid", arvalid, 1);
        check("c1_araddr", araddr, 32'h8000_0000);
        check("c1_s_ready", s_ready, 0);
        check("c1_rready", rready, 0);
        tick();
        check("c2_rready", rready, 1);
        check("c2_arvalid", arvalid, 0);
        check("c2_m_valid", m_valid, 0);
        tick();
        check("c3_m_valid", m_valid, 1);
        check("c3_inst", inst, 32'h0000_0413);
        check("c3_pc_out", pc_out, 32'h8000_0000);
        check("c3_fetch_err", fetch_err, 0);
        tick();
        check("c4_s_ready", s_ready, 1);
        check("c4_m_valid", m_valid, 0);

        // stalls: arready low 5 cycles, rvalid low 3 cycles, unaligned pc passes through
        pc = 32'h1000_0006; s_valid = 1'b1; arready = 1'b0; rvalid = 1'b0;
        tick();
        s_valid = 1'b0; pc = 32'hFFFF_FFFF;
        for (int c = 1; c <= 5; c++) begin
            check($sformatf("st_arvalid_c%0d", c), arvalid, 1);
            check($sformatf("st_araddr_c%0d", c), araddr, 32'h1000_0006);
            tick();
        end
        check("st_arvalid_c6", arvalid, 1);
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h1111_1111;
        tick();
        arready = 1'b0; rvalid = 1'b0;
        for (int c = 7; c <= 9; c++) begin
            check($sformatf("st_rready_c%0d", c), rready, 1);
            check($sformatf("st_arvalid_c%0d", c), arvalid, 0);
            check($sformatf("st_m_valid_c%0d", c), m_valid, 0);
            tick();
        end
        check("st_rready_c10", rready, 1);
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
        tick();
        rvalid = 1'b0;
        check("st_m_valid_c11", m_valid, 1);
        check("st_inst_c11", inst, 32'hDEAD_BEEF);
        check("st_pc_out_c11", pc_out, 32'h1000_0006);
        tick();
        check("st_idle", s_ready, 1);

        // error response, then hold with m_ready low
        pc = 32'h0000_0040; s_valid = 1'b1; arready = 1'b1; rvalid = 1'b1;
        rdata = 32'h1234_5678; rresp = 2'b10; m_ready = 1'b0;
        tick();
        s_valid = 1'b0;
        tick();
        tick();
        check("er_m_valid", m_valid, 1);
        check("er_fetch_err", fetch_err, 1);
        check("er_inst", inst, EBREAK);
        rresp = 2'b00;
        for (int c = 0; c < 4; c++) begin
            rdata = 32'hA5A5_0000 + 32'(c); pc = 32'h0000_0F00 + 32'(c); s_valid = 1'b1;
            tick();
            check($sformatf("hd_inst_%0d", c), inst, EBREAK);
            check($sformatf("hd_pc_out_%0d", c), pc_out, 32'h0000_0040);
            check($sformatf("hd_s_ready_%0d", c), s_ready, 0);
            check($sformatf("hd_m_valid_%0d", c), m_valid, 1);
            check($sformatf("hd_arvalid_%0d", c), arvalid, 0);
        end
        s_valid = 1'b0; m_ready = 1'b1;
        tick();
        check("hd_release", s_ready, 1);

        // reset during R
        pc = 32'h0000_0200; s_valid = 1'b1; arready = 1'b1; rvalid = 1'b0;
        tick();
        s_valid = 1'b0;
        tick();
        check("rr_rready_pre", rready, 1);
        rst = 1'b1;
        tick();
        check("rr_rready", rready, 0);
        check("rr_s_ready", s_ready, 1);
        check("rr_m_valid", m_valid, 0);
        rst = 1'b0;
        tick();

        // clean fetch after an error clears fetch_err
        pc = 32'h0000_0100; s_valid = 1'b1; arready = 1'b1; rvalid = 1'b1;
        rdata = 32'h00A0_0093; rresp = 2'b00; m_ready = 1'b1;
        tick();
        s_valid = 1'b0;
        tick();
        tick();
        check("ok_m_valid", m_valid, 1);
        check("ok_inst", inst, 32'h00A0_0093);
        check("ok_fetch_err", fetch_err, 0);
        check("ok_pc_out", pc_out, 32'h0000_0100);
        tick();

`ifdef IFU_TIMEOUT_EN
        // watchdog: arready stuck low, abort 9 cycles after entering AR
        pc = 32'h0000_0300; s_valid = 1'b1; arready = 1'b0; rvalid = 1'b0; m_ready = 1'b0;
        tick();
        s_valid = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            check($sformatf("to_arvalid_c%0d", c), arvalid, 1);
            check($sformatf("to_m_valid_c%0d", c), m_valid, 0);
            tick();
        end
        check("to_arvalid_drop", arvalid, 0);
        check("to_m_valid", m_valid, 1);
        check("to_fetch_err", fetch_err, 1);
        check("to_inst", inst, EBREAK);
        m_ready = 1'b1;
        tick();
        check("to_idle", s_ready, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ifu_axil_fetch.md
# ifu_axil_fetch

Instruction fetch stage that sits directly upstream of the decode stage bus. On a fetch request it issues one AXI4-Lite read for the current PC, waits for the response, and presents the instruction word to decode with a valid/ready handshake. Built to replace the fixed-latency instruction memory path, so the core runs against a variable-latency memory or bus.

## Interface
- `ADDR_W`, 32, width of PC and `araddr`
- `DATA_W`, 32, instruction and `rdata` width; only 32 is supported
- `TIMEOUT`, 255, cycles allowed per AR or R phase before an abort; used only with `IFU_TIMEOUT_EN`

- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `pc`  in  ADDR_W  fetch address, sampled when `s_valid && s_ready`
- `s_valid`  in  1  fetch request; may be a one-cycle pulse
- `s_ready`  out  1  high only in IDLE
- `inst`  out  DATA_W  fetched instruction, stable while `m_valid`
- `pc_out`  out  ADDR_W  address that `inst` came from
- `m_valid`  out  1  instruction available to decode
- `m_ready`  in  1  decode accepts
- `fetch_err`  out  1  qualifies the current `m_valid` beat as a failed fetch
- `araddr`  out  ADDR_W  AXI read address
- `arvalid`  out  1  AXI read address valid
- `arready`  in  1  AXI read address ready
- `rdata`  in  DATA_W  AXI read data
- `rresp`  in  2  AXI read response
- `rvalid`  in  1  AXI read data valid
- `rready`  out  1  AXI read data ready

## Operation
- FSM states: IDLE, AR, R, HOLD.
- IDLE: `s_ready`=1. On `s_valid`, latch `pc` into `addr_q` and go to AR. In all other states `s_valid` is ignored. Upstream does not re-request before completion.
- AR: `arvalid`=1, `araddr`=`addr_q`. On `arready`, go to R.
- R: `rready`=1. On `rvalid`:
  - `rresp`==0: latch `inst`=`rdata`, `fetch_err`=0.
  - `rresp`!=0: latch `inst`=32'h0010_0073 (ebreak), `fetch_err`=1.
  - Then go to HOLD.
- HOLD: `m_valid`=1. `inst`, `pc_out`=`addr_q` and `fetch_err` are held. On `m_ready`, go to IDLE.
- `araddr` is the full PC. Alignment is not checked; the low two bits pass through.
- Only one outstanding read is allowed. `arvalid` and `rready` are never high together.

## Timing
- Reset (asynchronous): state=IDLE. `s_ready`=1. `arvalid`, `rready`, `m_valid`, `fetch_err`=0. `inst`, `pc_out`, `addr_q`=0. Timeout counter=0.
- Outputs are registered or decoded from the state register only. There is no combinational path from any input to any output.
- Zero-wait memory: request accepted at edge 0, AR in cycle 1, R in cycle 2, `m_valid` in cycle 3. Minimum latency is 3 cycles.
- Each stall on `arready` or `rvalid` adds one cycle per stall cycle.
- With `m_ready` high in HOLD, IDLE follows at the next edge. Back-to-back fetches are therefore spaced at least 4 cycles apart.
- If `arready` and `rvalid` are both high in AR, only `arready` is honoured. `rvalid` is not consumed until R.
- Reset during AR or R abandons the transaction. The memory side shares `rst`, so no stale response is expected.

## Configuration
- `IFU_TIMEOUT_EN` defined:
  - Adds a counter of width $clog2(TIMEOUT+1). It is cleared on entering AR and on entering R, and increments each cycle in AR or R.
  - When it reaches `TIMEOUT`, the FSM goes to HOLD with `inst`=32'h0010_0073 and `fetch_err`=1.
  - On that abort, `arvalid` and `rready` drop. This intentionally breaks AXI protocol as a simulation-debug aid.
- `IFU_TIMEOUT_EN` undefined: no counter is instantiated, `TIMEOUT` is unused, and the FSM waits indefinitely in AR and R.

## Test plan
- Reset, then `s_valid` pulse with `pc`=0x8000_0000, `arready`=`rvalid`=1, `rdata`=0x0000_0413, `m_ready`=1 -> `araddr`=0x8000_0000 in cycle 1; `m_valid`=1, `inst`=0x0000_0413, `pc_out`=0x8000_0000 in cycle 3; `s_ready`=1 in cycle 4.
- `arready` low 5 cycles, then `rvalid` low 3 cycles -> `arvalid` held 6 cycles with `araddr` stable; `m_valid` in cycle 11.
- `rresp`=2'b10 -> `m_valid`=1, `fetch_err`=1, `inst`=0x0010_0073.
- `m_ready` low 4 cycles in HOLD while `rdata` and `pc` change -> `inst`/`pc_out` unchanged; `s_valid` ignored and `s_ready`=0 throughout.
- Assert `rst` in R state -> next cycle `rready`=0, `s_ready`=1, `m_valid`=0.
- `IFU_TIMEOUT_EN`, `TIMEOUT`=8, `arready` stuck low -> `arvalid` drops and `m_valid`=1 with `fetch_err`=1 exactly 9 cycles after entering AR.
